// File: rtl/prog_pkg.sv
// Shared definitions for the program loader and the PP instruction decoder.
package prog_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 11;

  // Instruction word layout, MSB first:
  // RegAddr[3:0], ALUCode[2:0], Reg_CE, CY_CE, A_CE, ResetCY
  localparam int unsigned REGADDR_LSB = 7;
  localparam int unsigned REGADDR_W   = 4;
  localparam int unsigned ALUCODE_LSB = 4;
  localparam int unsigned ALUCODE_W   = 3;
  localparam int unsigned REG_CE_BIT  = 3;
  localparam int unsigned CY_CE_BIT   = 2;
  localparam int unsigned A_CE_BIT    = 1;
  localparam int unsigned RESETCY_BIT = 0;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StDone,
    StError
  } loader_state_e;

endpackage

// File: rtl/prog_chk_acc.sv
// Running XOR of accepted program words; clear wins over enable.
module prog_chk_acc
  import prog_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] acc_o
);

  logic [DATA_W-1:0] acc_q;

  // Accumulator register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q ^ data_i;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/prog_loader.sv
// Program memory loader: streams instruction words into program memory from address 0 and
// holds the CPU datapath in reset until the program is fully written.
// Optional checksum beat after the program: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              cpu_nreset_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   length_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  loader_state_e state_q, state_d;

  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W:0]   length_q, length_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_nreset_q, cpu_nreset_d;

  logic beat_acc;
  logic prog_beat;
  logic final_beat;
  logic start_go;
  logic chk_beat;
  logic chk_ok;

  assign beat_acc   = in_valid_i && in_ready_o;
  assign prog_beat  = beat_acc && (state_q == StLoad);
  // The last location forces end of load so the address never wraps.
  assign final_beat = prog_beat && (in_last_i || (count_q == LastAddr));
  assign start_go   = start_i && ((state_q == StIdle) || (state_q == StDone) ||
                                  (state_q == StError));

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] acc;

  prog_chk_acc #(
    .DATA_W(DATA_W)
  ) u_chk_acc (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (start_go),
    .en_i   (prog_beat),
    .data_i (in_data_i),
    .acc_o  (acc)
  );

  assign chk_beat = beat_acc && (state_q == StCheck);
  assign chk_ok   = (in_data_i == acc);
`else
  assign chk_beat = 1'b0;
  assign chk_ok   = 1'b1;
`endif

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) state_d = StLoad;
      end
      StLoad: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        if (final_beat) state_d = StCheck;
`else
        if (final_beat) state_d = StDone;
`endif
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      StCheck: begin
        if (chk_beat) state_d = chk_ok ? StDone : StError;
      end
      StError: begin
        if (start_i) state_d = StLoad;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs decoded from state
  always_comb begin
    in_ready_o = (state_q == StLoad);
    done_o     = (state_q == StDone);
    err_o      = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    in_ready_o = in_ready_o || (state_q == StCheck);
    err_o      = (state_q == StError);
`endif
  end

  // Datapath next-state: write port, word counter, length, CPU reset
  always_comb begin
    count_d     = count_q;
    length_d    = length_q;
    mem_we_d    = prog_beat;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (start_go) begin
      count_d = '0;
    end else if (prog_beat && !final_beat) begin
      count_d = count_q + 1'b1;
    end
    if (final_beat) begin
      length_d = {1'b0, count_q} + {{ADDR_W{1'b0}}, 1'b1};
    end
    if (prog_beat) begin
      mem_addr_d  = count_q;
      mem_wdata_d = in_data_i;
    end
    // Release only after a full cycle in DONE, i.e. after the final write has landed.
    cpu_nreset_d = (state_q == StDone) && (state_d == StDone);
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q      <= '0;
      length_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_nreset_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      length_q     <= length_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_nreset_q <= cpu_nreset_d;
    end
  end

  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign cpu_nreset_o = cpu_nreset_q;
  assign length_o     = length_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader against a transaction-level reference model.
module tb_prog_loader;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 11;
  localparam int DEPTH  = 32;

  localparam int PIdle = 0;
  localparam int PLoad = 1;
  localparam int PChk  = 2;
  localparam int PDone = 3;
  localparam int PErr  = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_nreset;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   length;

  prog_loader dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_last_i    (in_last),
    .in_ready_o   (in_ready),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .cpu_nreset_o (cpu_nreset),
    .done_o       (done),
    .err_o        (err),
    .length_o     (length)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image of what the DUT actually wrote into program memory.
  logic [DATA_W-1:0] dut_mem [DEPTH];
  logic              clr_mem;
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < DEPTH; i++) dut_mem[i] <= 'x;
    end else if (mem_we) begin
      dut_mem[mem_addr] <= mem_wdata;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  int m_phase;
  bit m_we;
  int m_wa;
  int m_wd;
  bit m_nrst;
  int m_cnt;
  int m_len;
  int m_xor;
  int prog[$];
  int dq[$];
  bit cs_good = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit m_ready();
    return (m_phase == PLoad) || (m_phase == PChk);
  endfunction

  task automatic model_reset();
    m_phase = PIdle;
    m_we = 0; m_wa = 0; m_wd = 0; m_nrst = 0;
    m_cnt = 0; m_len = 0; m_xor = 0;
    prog.delete();
  endtask

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_edge();
    int old;
    old = m_phase;
    m_we = 0;
    case (m_phase)
      PIdle, PDone, PErr: begin
        if (start) begin
          m_phase = PLoad; m_cnt = 0; m_xor = 0; prog.delete();
        end
      end
      PLoad: begin
        if (in_valid) begin
          m_we = 1; m_wa = m_cnt; m_wd = int'(in_data);
          m_xor = m_xor ^ int'(in_data);
          prog.push_back(int'(in_data));
          if (in_last || m_cnt == DEPTH - 1) begin
            m_len = m_cnt + 1;
`ifdef PROG_LOADER_CHECKSUM_EN
            m_phase = PChk;
`else
            m_phase = PDone;
`endif
          end else begin
            m_cnt++;
          end
        end
      end
      PChk: begin
        if (in_valid) m_phase = (int'(in_data) == m_xor) ? PDone : PErr;
      end
      default: ;
    endcase
    m_nrst = (old == PDone) && (m_phase == PDone);
  endtask

  task automatic check_outputs();
    chk("in_ready", in_ready, m_ready());
    chk("done", done, m_phase == PDone);
    chk("err", err, m_phase == PErr);
    chk("cpu_nreset", cpu_nreset, m_nrst);
    chk("length", length, m_len);
    chk("mem_we", mem_we, m_we);
    if (m_we) begin
      chk("mem_addr", mem_addr, m_wa);
      chk("mem_wdata", mem_wdata, m_wd);
    end
  endtask

  // Check mid-cycle, then advance model and DUT through one rising edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // mode 0: valid every cycle, 1: random gaps plus stray starts, 2: alternating valid.
  task automatic do_load(input int last_idx, input int mode);
    int i;
    int budget;
    bit v;
    i = 0;
    budget = 0;
    clr_mem = 1; start = 1; in_valid = 0; in_last = 0;
    cycle();
    clr_mem = 0; start = 0;
    while (m_phase == PLoad && budget < 400) begin
      budget++;
      case (mode)
        0: v = 1'b1;
        1: v = ($urandom_range(0, 2) != 0);
        default: v = (budget % 2) == 1;
      endcase
      in_valid = v;
      in_data  = (i < dq.size()) ? DATA_W'(dq[i]) : DATA_W'($urandom);
      in_last  = (i == last_idx);
      if (mode == 1) start = ($urandom_range(0, 4) == 0);
      cycle();
      if (v) i++;
    end
    start = 0;
    while (m_phase == PChk && budget < 400) begin
      budget++;
      in_valid = 1; in_last = 0;
      in_data  = cs_good ? DATA_W'(m_xor) : DATA_W'(m_xor ^ 1);
      cycle();
    end
    chk("load_budget", budget < 400, 1);
    in_valid = 0; in_last = 0;
    repeat (3) cycle();
    for (int k = 0; k < m_len; k++) chk("mem_img", dut_mem[k], prog[k]);
  endtask

  initial begin
    rst_n = 0; start = 0; in_valid = 0; in_data = '0; in_last = 0; clr_mem = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst_n = 1;
    repeat (2) cycle();

    // Three-word program with last on the third beat.
    dq = '{'h101, 'h202, 'h7FF};
    do_load(2, 0);
    chk("len3", length, 3);
    chk("done3", done, 1);

    // Full-depth load with in_last never set; restart from DONE.
    dq.delete();
    do_load(-1, 0);
    chk("len32", length, 32);
    in_valid = 1; in_last = 1; in_data = 'h3AA;
    repeat (3) cycle();
    in_valid = 0; in_last = 0;

    // Valid toggling 1,0,1.
    dq = '{'h011, 'h022};
    do_load(1, 2);
    chk("len_gap", length, 2);

    // Asynchronous reset after two of five beats.
    clr_mem = 1; start = 1;
    cycle();
    clr_mem = 0; start = 0;
    in_valid = 1; in_last = 0;
    repeat (2) begin
      in_data = DATA_W'($urandom);
      cycle();
    end
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check_outputs();
    chk("arst_we", mem_we, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    in_valid = 0;
    repeat (2) cycle();
    dq.delete();
    do_load(4, 0);
    chk("len5", length, 5);

`ifdef PROG_LOADER_CHECKSUM_EN
    dq = '{'h003, 'h005};
    cs_good = 1;
    do_load(1, 0);
    chk("cs_done", done, 1);
    cs_good = 0;
    do_load(1, 0);
    chk("cs_err", err, 1);
    chk("cs_nrst", cpu_nreset, 0);
    cs_good = 1;
`endif

    // Randomised loads with gaps and stray start pulses.
    repeat (5) begin
      dq.delete();
`ifdef PROG_LOADER_CHECKSUM_EN
      cs_good = ($urandom_range(0, 1) == 1);
`endif
      do_load($urandom_range(0, 40), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
